parallax_layers_gen: RTL

- Parametrised multi-layer parallax checkerboard renderer for the TinyVGA 640x480 demo designs.
- Sits between `hvsync_generator` and the PMOD output mapping. It consumes pixel coordinates and sync signals, and produces registered 2-2-2 RGB plus sync delayed to match.
- Successor to the fixed five-layer checker effect. Layer count, checker scale, per-layer dithering, speed, pause/single-step and reverse scrolling are all configurable.
- The frame counter is clocked by `clk` with vsync edge detection; it is not clocked by vsync directly.

---
 rtl/parallax_layers_gen_pkg.sv | 26 ++
 rtl/parallax_layers_gen_if.sv | 24 ++
 rtl/parallax_layers_gen_frame_ctr.sv | 54 +++++
 rtl/parallax_layers_gen.sv | 120 ++++++++++++
 4 files changed

// File: rtl/parallax_layers_gen_pkg.sv
// Shared types and helpers for the parallax checkerboard renderer.
// Dither codes, the odd-layer colour twist and the per-channel shade function.
package parallax_pkg;

  typedef enum logic [1:0] {
    DITHER_NONE = 2'd0,
    DITHER_A    = 2'd1,
    DITHER_B    = 2'd2,
    DITHER_RSVD = 2'd3
  } dither_e;

  // Odd layers flip the high bit of G and B to alternate hue between depths.
  localparam logic [5:0] ODD_XOR = 6'b00_10_10;

  // Darken a {R,G,B} 2-2-2 colour by shifting each channel right independently.
  function automatic logic [5:0] shade(input logic [5:0] col6, input logic [1:0] sh);
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    r = col6[5:4] >> sh;
    g = col6[3:2] >> sh;
    b = col6[1:0] >> sh;
    return {r, g, b};
  endfunction

endpackage

// File: rtl/parallax_layers_gen_if.sv
// Pixel stream in (coordinates, enable, syncs) and colour/sync stream out.
// The timing generator side is master, the renderer is slave.
interface parallax_layers_gen_if #(
  parameter int COORD_W = 10
);
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               video_active;
  logic               hsync_in;
  logic               vsync_in;
  logic [5:0]         rgb;
  logic               hsync_out;
  logic               vsync_out;

  modport master (
    output pix_x, pix_y, video_active, hsync_in, vsync_in,
    input  rgb, hsync_out, vsync_out
  );

  modport slave (
    input  pix_x, pix_y, video_active, hsync_in, vsync_in,
    output rgb, hsync_out, vsync_out
  );
endinterface

// File: rtl/parallax_layers_gen_frame_ctr.sv
// Frame counter advanced on vsync rising edges seen in the clk domain,
// with pause, single-step latch, reverse direction and natural wrap.
module parallax_frame_ctr #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             pause,
  input  logic             step,
  input  logic             reverse,
  output logic [CNT_W-1:0] frame_count,
  output logic             tick
);

  logic             vsync_prev_reg;
  logic             primed_reg;
  logic             step_pending_reg;
  logic [CNT_W-1:0] count_reg;

  logic             advance;
  logic             pending_next;
  logic [CNT_W-1:0] count_next;

  // primed_reg masks the first cycle after reset so a vsync already high at
  // release is not mistaken for a rising edge.
  assign tick = vsync & ~vsync_prev_reg & primed_reg;

  always_comb begin
    advance      = tick & (~pause | step_pending_reg | step);
    pending_next = tick ? 1'b0 : (step_pending_reg | step);
    count_next   = count_reg;
    if (advance) begin
      count_next = reverse ? (count_reg - CNT_W'(1)) : (count_reg + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_reg   <= 1'b0;
      primed_reg       <= 1'b0;
      step_pending_reg <= 1'b0;
      count_reg        <= '0;
    end else begin
      vsync_prev_reg   <= vsync;
      primed_reg       <= 1'b1;
      step_pending_reg <= pending_next;
      count_reg        <= count_next;
    end
  end

  assign frame_count = count_reg;

endmodule

// File: rtl/parallax_layers_gen.sv
// Multi-layer parallax checkerboard: per-layer scrolled checker hit, priority
// pick of the nearest layer, two-stage registered colour with matched syncs.
module parallax_layers_gen
  import parallax_pkg::*;
#(
  parameter int          NUM_LAYERS = 5,
  parameter int          COORD_W    = 10,
  parameter int          CNT_W      = 10,
  parameter int          TOP_BIT    = 8,
  parameter logic [15:0] DITHER_SEL = 16'h2001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parallax_layers_gen_if.slave  vid,
  input  logic [5:0]            base_color,
  input  logic                  pause,
  input  logic                  step,
  input  logic                  reverse,
  input  logic [1:0]            speed,
  output logic [CNT_W-1:0]      frame_count
);

  // Scaled count keeps the bits pushed up by speed so deeper layers still see them.
  localparam int SCALED_W = CNT_W + 3;

  logic [SCALED_W-1:0]   scaled;
  logic [5:0]            c0;
  logic [NUM_LAYERS-1:0] hit;
  logic [5:0]            layer_col [NUM_LAYERS];
  logic [5:0]            win_col;

  logic [NUM_LAYERS-1:0] hit_s1_reg;
  logic [5:0]            col_s1_reg;
  logic                  active_s1_reg;
  logic                  hs_s1_reg;
  logic                  vs_s1_reg;
  logic [5:0]            rgb_reg;
  logic                  hs_s2_reg;
  logic                  vs_s2_reg;

  parallax_frame_ctr #(
    .CNT_W(CNT_W)
  ) u_frame_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vid.vsync_in),
    .pause      (pause),
    .step       (step),
    .reverse    (reverse),
    .frame_count(frame_count),
    .tick       ()
  );

  assign scaled = SCALED_W'(frame_count) << speed;
  assign c0     = ~base_color;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    logic [COORD_W-1:0] xo;
    logic [COORD_W-1:0] yo;
    logic [COORD_W-1:0] lx;
    logic [COORD_W-1:0] ly;
    logic [1:0]         code;
    logic               dither;

    // Farther layers scroll at half the speed of the one in front; vertical drift is 1/8.
    assign xo   = COORD_W'(scaled >> gi);
    assign yo   = xo >> 3;
    assign lx   = vid.pix_x + xo;
    assign ly   = vid.pix_y + yo;
    assign code = DITHER_SEL[2*gi +: 2];

    always_comb begin
      case (dither_e'(code))
        DITHER_A: dither = vid.pix_y[1] ^ vid.pix_x[0];
        DITHER_B: dither = ~vid.pix_y[0] ^ vid.pix_x[1];
        default:  dither = 1'b1;
      endcase
    end

    assign hit[gi]       = (lx[TOP_BIT-gi] ^ ly[TOP_BIT-gi]) & dither;
    assign layer_col[gi] = shade(c0 ^ (((gi % 2) == 1) ? ODD_XOR : 6'd0), 2'(gi >> 1));
  end

  // Walk from the far layer toward the near one so the lowest index hit wins.
  always_comb begin
    win_col = 6'd0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_col = layer_col[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_s1_reg    <= '0;
      col_s1_reg    <= 6'd0;
      active_s1_reg <= 1'b0;
      hs_s1_reg     <= 1'b0;
      vs_s1_reg     <= 1'b0;
      rgb_reg       <= 6'd0;
      hs_s2_reg     <= 1'b0;
      vs_s2_reg     <= 1'b0;
    end else begin
      hit_s1_reg    <= hit;
      col_s1_reg    <= win_col;
      active_s1_reg <= vid.video_active;
      hs_s1_reg     <= vid.hsync_in;
      vs_s1_reg     <= vid.vsync_in;
      rgb_reg       <= (active_s1_reg && (|hit_s1_reg)) ? col_s1_reg : 6'd0;
      hs_s2_reg     <= hs_s1_reg;
      vs_s2_reg     <= vs_s1_reg;
    end
  end

  assign vid.rgb       = rgb_reg;
  assign vid.hsync_out = hs_s2_reg;
  assign vid.vsync_out = vs_s2_reg;

endmodule
